// File: rtl/pe_inject_vc.sv
// PE injection port: per-VC FWFT FIFOs fed from the PE, each head requesting the
// cw or ccw ring output according to its direction bit.
module pe_inject_vc #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned NUM_VC     = 2,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned DIR_BIT    = 62,
  localparam int unsigned VC_W      = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
  localparam int unsigned CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           pesi,
  input  logic [DATA_WIDTH-1:0]          pedi,
  input  logic [VC_W-1:0]                vc_sel,
  output logic                           peri,
  output logic [NUM_VC-1:0]              req_cw,
  output logic [NUM_VC-1:0]              req_ccw,
  input  logic [NUM_VC-1:0]              gnt_cw,
  input  logic [NUM_VC-1:0]              gnt_ccw,
  output logic [NUM_VC*DATA_WIDTH-1:0]   data_cw,
  output logic [NUM_VC*DATA_WIDTH-1:0]   data_ccw,
  output logic [NUM_VC*CNT_W-1:0]        occ,
  output logic                           err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q    [NUM_VC][DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q [NUM_VC];
  logic [PTR_W-1:0]      rd_ptr_q [NUM_VC];
  logic [CNT_W-1:0]      cnt_q    [NUM_VC];
  logic                  err_q;

  logic [DATA_WIDTH-1:0] head [NUM_VC];
  logic [NUM_VC-1:0]     empty, full, dir, push, pop;
  logic                  sel_valid, sel_full, err_set;

  always_comb begin
    sel_valid = 1'b0;
    sel_full  = 1'b0;
    for (int v = 0; v < NUM_VC; v++) begin
      empty[v] = (cnt_q[v] == '0);
      full[v]  = (cnt_q[v] == CNT_W'(DEPTH));
      head[v]  = mem_q[v][rd_ptr_q[v]];
      dir[v]   = head[v][DIR_BIT];
      if (vc_sel == VC_W'(v)) begin
        sel_valid = 1'b1;
        sel_full  = full[v];
      end
    end
  end

  // Ready never looks at same-cycle grants: no push into a full FIFO even if it pops.
  assign peri    = sel_valid & ~sel_full;
  assign req_cw  = ~empty & ~dir;
  assign req_ccw = ~empty & dir;

  always_comb begin
    for (int v = 0; v < NUM_VC; v++) begin
      push[v] = pesi & peri & (vc_sel == VC_W'(v));
      pop[v]  = ((gnt_cw[v] & req_cw[v]) | (gnt_ccw[v] & req_ccw[v]))
                & ~(gnt_cw[v] & gnt_ccw[v]);
    end
  end

  // Out-of-range vc_sel with pesi is caught by the ~peri term.
  assign err_set = (pesi & ~peri)
                 | (|(gnt_cw & ~req_cw))
                 | (|(gnt_ccw & ~req_ccw))
                 | (|(gnt_cw & gnt_ccw));

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
      for (int v = 0; v < NUM_VC; v++) begin
        wr_ptr_q[v] <= '0;
        rd_ptr_q[v] <= '0;
        cnt_q[v]    <= '0;
        for (int d = 0; d < DEPTH; d++) begin
          mem_q[v][d] <= '0;
        end
      end
    end else begin
      err_q <= err_q | err_set;
      for (int v = 0; v < NUM_VC; v++) begin
        if (push[v]) begin
          mem_q[v][wr_ptr_q[v]] <= pedi;
          wr_ptr_q[v]           <= wr_ptr_q[v] + PTR_W'(1);
        end
        if (pop[v]) begin
          rd_ptr_q[v] <= rd_ptr_q[v] + PTR_W'(1);
        end
        if (push[v] && !pop[v]) begin
          cnt_q[v] <= cnt_q[v] + CNT_W'(1);
        end else if (pop[v] && !push[v]) begin
          cnt_q[v] <= cnt_q[v] - CNT_W'(1);
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_VC; g++) begin : g_out
    assign data_cw[g*DATA_WIDTH +: DATA_WIDTH]  = head[g];
    assign data_ccw[g*DATA_WIDTH +: DATA_WIDTH] = head[g];
    assign occ[g*CNT_W +: CNT_W]                = cnt_q[g];
  end

  assign err = err_q;

endmodule

// File: tb/tb_pe_inject_vc.sv
// Bench for pe_inject_vc: table of per-cycle stimulus with hand-derived expectations,
// plus a per-VC packet scoreboard checking head data at every expected pop.
module tb_pe_inject_vc;

  logic         clk = 1'b0;
  logic         rst, pesi, vc_sel, peri, err;
  logic [63:0]  pedi;
  logic [1:0]   req_cw, req_ccw, gnt_cw, gnt_ccw;
  logic [127:0] data_cw, data_ccw;
  logic [5:0]   occ;

  int checks = 0;
  int errors = 0;

  logic [63:0] q0[$];
  logic [63:0] q1[$];

  pe_inject_vc #(
    .DATA_WIDTH(64),
    .NUM_VC    (2),
    .DEPTH     (4),
    .DIR_BIT   (62)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .pesi    (pesi),
    .pedi    (pedi),
    .vc_sel  (vc_sel),
    .peri    (peri),
    .req_cw  (req_cw),
    .req_ccw (req_ccw),
    .gnt_cw  (gnt_cw),
    .gnt_ccw (gnt_ccw),
    .data_cw (data_cw),
    .data_ccw(data_ccw),
    .occ     (occ),
    .err     (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        pesi;
    logic [63:0] pedi;
    logic        vc;
    logic [1:0]  gcw;
    logic [1:0]  gccw;
    logic        peri;
    logic [1:0]  rcw;
    logic [1:0]  rccw;
    logic [2:0]  occ0;
    logic [2:0]  occ1;
    logic        err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic ps, logic [63:0] pd, logic vc, logic [1:0] gcw,
                              logic [1:0] gccw, logic pr, logic [1:0] rcw, logic [1:0] rccw,
                              logic [2:0] o0, logic [2:0] o1, logic e);
    vec_t t;
    t.rst = r;  t.pesi = ps; t.pedi = pd; t.vc = vc; t.gcw = gcw; t.gccw = gccw;
    t.peri = pr; t.rcw = rcw; t.rccw = rccw; t.occ0 = o0; t.occ1 = o1; t.err = e;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic int qsize(int v);
    return (v == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [63:0] qhead(int v);
    return (v == 0) ? q0[0] : q1[0];
  endfunction

  task automatic apply(input vec_t t, input int idx);
    logic [63:0] hd;
    logic        mcw, mccw;
    @(negedge clk);
    rst = t.rst; pesi = t.pesi; pedi = t.pedi; vc_sel = t.vc;
    gnt_cw = t.gcw; gnt_ccw = t.gccw;
    #1;
    chk($sformatf("row%0d peri", idx), peri, t.peri);
    // Scoreboard: pops decided on the model's pre-edge heads, before any push.
    for (int v = 0; v < 2; v++) begin
      mcw  = 1'b0;
      mccw = 1'b0;
      if (qsize(v) > 0) begin
        mccw = qhead(v)[62];
        mcw  = ~qhead(v)[62];
      end
      if (!t.rst && ((t.gcw[v] && mcw) || (t.gccw[v] && mccw)) && !(t.gcw[v] && t.gccw[v]))
      begin
        if (v == 0) hd = q0.pop_front();
        else        hd = q1.pop_front();
        chk($sformatf("row%0d data_cw vc%0d", idx, v), data_cw[v*64 +: 64], hd);
        chk($sformatf("row%0d data_ccw vc%0d", idx, v), data_ccw[v*64 +: 64], hd);
      end
    end
    if (t.rst) begin
      q0.delete();
      q1.delete();
    end else if (t.pesi && qsize(int'(t.vc)) < 4) begin
      if (t.vc == 1'b0) q0.push_back(t.pedi);
      else              q1.push_back(t.pedi);
    end
    @(posedge clk);
    #1;
    chk($sformatf("row%0d req_cw", idx), req_cw, t.rcw);
    chk($sformatf("row%0d req_ccw", idx), req_ccw, t.rccw);
    chk($sformatf("row%0d occ", idx), occ, {t.occ1, t.occ0});
    chk($sformatf("row%0d err", idx), err, t.err);
  endtask

  localparam logic [63:0] PA = 64'h4000_0000_0000_00AA;  // ccw
  localparam logic [63:0] PB = 64'h0000_0000_0000_00BB;  // cw
  localparam logic [63:0] PG = 64'h4000_0000_0000_0066;  // ccw

  initial begin
    rst = 1'b1; pesi = 1'b0; pedi = '0; vc_sel = 1'b0; gnt_cw = '0; gnt_ccw = '0;
    repeat (2) @(posedge clk);

    //            rst  pesi pedi       vc    gcw    gccw  peri rcw    rccw   o0 o1 err
    tbl.push_back(mk(0, 0, 64'h0,      0, 2'b00, 2'b00, 1, 2'b00, 2'b00, 0, 0, 0)); // 0 idle
    tbl.push_back(mk(0, 1, 64'h0,      1, 2'b00, 2'b00, 1, 2'b10, 2'b00, 0, 1, 0)); // 1
    tbl.push_back(mk(0, 0, 64'h0,      0, 2'b10, 2'b00, 1, 2'b00, 2'b00, 0, 0, 0)); // 2
    tbl.push_back(mk(0, 1, 64'h0C01,   0, 2'b00, 2'b00, 1, 2'b01, 2'b00, 1, 0, 0)); // 3
    tbl.push_back(mk(0, 1, 64'h0C02,   0, 2'b00, 2'b00, 1, 2'b01, 2'b00, 2, 0, 0)); // 4
    tbl.push_back(mk(0, 1, 64'h0C03,   0, 2'b00, 2'b00, 1, 2'b01, 2'b00, 3, 0, 0)); // 5
    tbl.push_back(mk(0, 1, 64'h0C04,   0, 2'b00, 2'b00, 1, 2'b01, 2'b00, 4, 0, 0)); // 6
    tbl.push_back(mk(0, 0, 64'h0,      1, 2'b00, 2'b00, 1, 2'b01, 2'b00, 4, 0, 0)); // 7
    tbl.push_back(mk(0, 1, 64'hDEAD,   0, 2'b00, 2'b00, 0, 2'b01, 2'b00, 4, 0, 1)); // 8 drop
    tbl.push_back(mk(0, 0, 64'h0,      0, 2'b01, 2'b00, 0, 2'b01, 2'b00, 3, 0, 1)); // 9
    tbl.push_back(mk(0, 0, 64'h0,      0, 2'b01, 2'b00, 1, 2'b01, 2'b00, 2, 0, 1)); // 10
    tbl.push_back(mk(0, 0, 64'h0,      0, 2'b01, 2'b00, 1, 2'b01, 2'b00, 1, 0, 1)); // 11
    tbl.push_back(mk(0, 0, 64'h0,      0, 2'b01, 2'b00, 1, 2'b00, 2'b00, 0, 0, 1)); // 12
    tbl.push_back(mk(0, 1, PA,         0, 2'b00, 2'b00, 1, 2'b00, 2'b01, 1, 0, 1)); // 13
    tbl.push_back(mk(0, 1, PB,         0, 2'b00, 2'b00, 1, 2'b00, 2'b01, 2, 0, 1)); // 14
    tbl.push_back(mk(0, 0, 64'h0,      0, 2'b00, 2'b01, 1, 2'b01, 2'b00, 1, 0, 1)); // 15
    tbl.push_back(mk(0, 0, 64'h0,      0, 2'b01, 2'b00, 1, 2'b00, 2'b00, 0, 0, 1)); // 16
    tbl.push_back(mk(0, 1, 64'hD1,     1, 2'b00, 2'b00, 1, 2'b10, 2'b00, 0, 1, 1)); // 17
    tbl.push_back(mk(0, 1, 64'hD2,     1, 2'b00, 2'b00, 1, 2'b10, 2'b00, 0, 2, 1)); // 18
    tbl.push_back(mk(0, 1, 64'hD3,     1, 2'b10, 2'b00, 1, 2'b10, 2'b00, 0, 2, 1)); // 19
    tbl.push_back(mk(0, 0, 64'h0,      1, 2'b10, 2'b00, 1, 2'b10, 2'b00, 0, 1, 1)); // 20
    tbl.push_back(mk(0, 0, 64'h0,      1, 2'b10, 2'b00, 1, 2'b00, 2'b00, 0, 0, 1)); // 21
    tbl.push_back(mk(0, 1, 64'hEE,     0, 2'b00, 2'b00, 1, 2'b01, 2'b00, 1, 0, 1)); // 22
    tbl.push_back(mk(1, 1, 64'h4F,     1, 2'b01, 2'b00, 1, 2'b00, 2'b00, 0, 0, 0)); // 23 rst
    tbl.push_back(mk(0, 0, 64'h0,      0, 2'b00, 2'b01, 1, 2'b00, 2'b00, 0, 0, 1)); // 24
    tbl.push_back(mk(0, 1, PG,         0, 2'b01, 2'b00, 1, 2'b00, 2'b01, 1, 0, 1)); // 25
    tbl.push_back(mk(0, 0, 64'h0,      0, 2'b01, 2'b01, 1, 2'b00, 2'b01, 1, 0, 1)); // 26
    tbl.push_back(mk(0, 0, 64'h0,      0, 2'b01, 2'b00, 1, 2'b00, 2'b01, 1, 0, 1)); // 27
    tbl.push_back(mk(0, 0, 64'h0,      0, 2'b00, 2'b01, 1, 2'b00, 2'b00, 0, 0, 1)); // 28

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], i);
    end

    // Model must have seen every packet leave.
    chk("sb vc0 drained", 64'(q0.size()), 64'd0);
    chk("sb vc1 drained", 64'(q1.size()), 64'd0);

    // Reset clears storage, so both data buses read zero afterwards.
    @(negedge clk);
    rst = 1'b1; pesi = 1'b0; vc_sel = 1'b0; gnt_cw = '0; gnt_ccw = '0;
    @(posedge clk);
    #1;
    chk("post-rst data_cw", data_cw, 128'h0);
    chk("post-rst data_ccw", data_ccw, 128'h0);
    chk("post-rst peri vc0", peri, 1'b1);
    chk("post-rst err", err, 1'b0);
    @(negedge clk);
    vc_sel = 1'b1;
    #1;
    chk("post-rst peri vc1", peri, 1'b1);
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, expected finish before 100000");
    $fatal(1);
  end

endmodule
